inv_cipher: RTL and testbench

//  Iterative AES-128 decryption datapath: one ciphertext block in, one plaintext block out.

---
 rtl/inv_cipher_pkg.sv | 35 +++
 rtl/inv_cipher_if.sv | 24 ++
 rtl/inv_sbox.sv | 30 +++
 rtl/inv_cipher.sv | 148 ++++++++++++++
 tb/tb_inv_cipher.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/inv_cipher_pkg.sv
// Shared AES widths, FSM encodings and GF(2^8) helpers for the cipher cores.
// Also used by the encrypt side so both cores agree on state encodings.
package inv_cipher_pkg;

    localparam int BLK_S = 128;
    localparam int KEY_S = 128;
    localparam int NR    = 10;

    typedef logic [0:BLK_S-1] blk_t;
    typedef logic [0:KEY_S-1] key_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ARK   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_cipher_if.sv
// Block/key-SRAM bundle for inv_cipher.
// The master side supplies ciphertext and SRAM read data; the core is the slave.
interface inv_cipher_if;
    import inv_cipher_pkg::*;

    logic       en;
    blk_t       ciphertext;
    key_t       key;
    blk_t       plaintext;
    logic [0:3] round_no;
    logic       r_e;
    logic       en_o;

    modport master (
        output en, ciphertext, key,
        input  plaintext, round_no, r_e, en_o
    );

    modport slave (
        input  en, ciphertext, key,
        output plaintext, round_no, r_e, en_o
    );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box for one byte.
// Inverse affine map followed by the GF(2^8) inverse taken as x^254.
module inv_sbox
    import inv_cipher_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [7:0] a;
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x12;
    logic [7:0] x15;
    logic [7:0] x240;

    always_comb begin
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
          ^ {x[1:0], x[7:2]} ^ 8'h05;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        y    = gf_mul(gf_mul(x240, x12), x2);
    end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 decryption core; round keys rk10..rk0 read from a shared key SRAM.
// Define AES_INV_SBOX_REG_EN to register InvSubBytes (two cycles per round, 22-cycle latency).
module inv_cipher
    import inv_cipher_pkg::*;
(
    input logic         clk,
    input logic         reset,
    inv_cipher_if.slave bus
);
    logic [2:0] state;
    logic [3:0] cnt;
    blk_t       st;
    blk_t       sr;
    blk_t       sb;
`ifdef AES_INV_SBOX_REG_EN
    blk_t       sbr;
    logic       ph;
`endif

    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = s[8*(4*((c-r)&3)+r) +: 8];
        return o;
    endfunction

    function automatic blk_t add_round_key(input blk_t s, input key_t k);
        return s ^ k;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c    +: 8];
            a1 = s[32*c+8  +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                            ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c+8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                            ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                            ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                            ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign sr = inv_shift_rows(st);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        inv_sbox u_sbox (.x(sr[8*g +: 8]), .y(sb[8*g +: 8]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            st            <= '0;
`ifdef AES_INV_SBOX_REG_EN
            sbr           <= '0;
            ph            <= 1'b0;
`endif
            bus.plaintext <= '0;
            bus.round_no  <= 4'd0;
            bus.r_e       <= 1'b0;
            bus.en_o      <= 1'b0;
        end else begin
            bus.en_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        st           <= bus.ciphertext;
                        bus.round_no <= 4'(NR);
                        bus.r_e      <= 1'b1;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state <= S_ARK;
`ifdef AES_INV_SBOX_REG_EN
                    bus.r_e <= 1'b0;
`else
                    bus.round_no <= bus.round_no - 4'd1;
`endif
                end
                S_ARK: begin
                    st    <= add_round_key(st, bus.key);
                    cnt   <= 4'd9;
                    state <= S_ROUND;
`ifdef AES_INV_SBOX_REG_EN
                    ph           <= 1'b0;
                    bus.r_e      <= 1'b1;
                    bus.round_no <= 4'd9;
`else
                    bus.round_no <= bus.round_no - 4'd1;
`endif
                end
                S_ROUND: begin
`ifdef AES_INV_SBOX_REG_EN
                    // the key for this round is requested one cycle before SUB
                    if (!ph) begin
                        sbr     <= sb;
                        bus.r_e <= 1'b0;
                        ph      <= 1'b1;
                    end else begin
                        st <= inv_mix_columns(add_round_key(sbr, bus.key));
                        bus.r_e      <= 1'b1;
                        bus.round_no <= cnt - 4'd1;
                        ph           <= 1'b0;
                        if (cnt == 4'd1) state <= S_FINAL;
                        else cnt <= cnt - 4'd1;
                    end
`else
                    st <= inv_mix_columns(add_round_key(sb, bus.key));
                    if (bus.round_no != 4'd0) bus.round_no <= bus.round_no - 4'd1;
                    else bus.r_e <= 1'b0;
                    if (cnt == 4'd1) state <= S_FINAL;
                    else cnt <= cnt - 4'd1;
`endif
                end
                S_FINAL: begin
`ifdef AES_INV_SBOX_REG_EN
                    if (!ph) begin
                        sbr     <= sb;
                        bus.r_e <= 1'b0;
                        ph      <= 1'b1;
                    end else begin
                        bus.plaintext <= add_round_key(sbr, bus.key);
                        bus.en_o      <= 1'b1;
                        ph            <= 1'b0;
                        state         <= S_IDLE;
                    end
`else
                    bus.plaintext <= add_round_key(sb, bus.key);
                    bus.en_o      <= 1'b1;
                    state         <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher with a registered key SRAM model.
// Build with AES_INV_SBOX_REG_EN to exercise the registered-S-box variant.
module tb_inv_cipher;

`ifdef AES_INV_SBOX_REG_EN
    localparam int LAT = 22;
`else
    localparam int LAT = 12;
`endif

    localparam logic [0:127] K1  = 128'h5468617473206d79204b756e67204675;
    localparam logic [0:127] CT1 = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [0:127] PT1 = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [0:127] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] P6  = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    logic [7:0]   sbox [256];
    logic [0:127] rk   [16];

    inv_cipher_if bus ();

    inv_cipher dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key SRAM: registered read, data held while r_e is low
    always @(posedge clk) begin
        if (reset) bus.key <= '0;
        else if (bus.r_e) bus.key <= rk[bus.round_no];
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // forward S-box built from a brute-force field inverse
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [0:127] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
                  ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] aes_enc(input logic [0:127] p);
        logic [0:127] s;
        logic [0:127] t;
        logic [7:0] a0, a1, a2, a3;
        s = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[8*(4*c+w) +: 8] = sbox[s[8*(4*((c+w)%4)+w) +: 8]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[32*c +: 8];
                    a1 = t[32*c+8 +: 8];
                    a2 = t[32*c+16 +: 8];
                    a3 = t[32*c+24 +: 8];
                    t[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = t ^ rk[r];
        end
        return s;
    endfunction

    // start one block; optionally re-assert en with another ct at edge inj_at
    task automatic run_block(input logic [0:127] ct, input int inj_at,
                             input logic [0:127] inj_ct,
                             output logic [0:127] pt, output int lat,
                             output int pulses, output int re_n,
                             output logic [43:0] seq);
        pt = '0;
        lat = 0;
        pulses = 0;
        re_n = 0;
        seq = '0;
        bus.ciphertext = ct;
        bus.en = 1'b1;
        @(posedge clk); #1;
        if (bus.r_e) begin re_n++; seq = {seq[39:0], bus.round_no}; end
        for (int n = 1; n <= 40; n++) begin
            bus.en = (n == inj_at);
            if (n == inj_at) bus.ciphertext = inj_ct;
            @(posedge clk); #1;
            if (bus.r_e) begin re_n++; seq = {seq[39:0], bus.round_no}; end
            if (bus.en_o) begin
                pulses++;
                if (lat == 0) begin
                    lat = n;
                    pt = bus.plaintext;
                end
            end
        end
        bus.en = 1'b0;
    endtask

    logic [0:127] pt;
    logic [0:127] ct6;
    int           lat;
    int           pulses;
    int           re_n;
    logic [43:0]  seq;

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.ciphertext = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_plaintext", bus.plaintext, 0);
        check("rst_round_no", bus.round_no, 0);
        check("rst_r_e", bus.r_e, 0);
        check("rst_en_o", bus.en_o, 0);
        reset = 1'b0;

        set_key(K1);
        run_block(CT1, 0, '0, pt, lat, pulses, re_n, seq);
        check("c1_pt", pt, PT1);
        check("c1_latency", lat, LAT);
        check("c1_pulses", pulses, 1);
        check("c3_re_cycles", re_n, 11);
        check("c3_round_seq", seq, 44'hA9876543210);
        check("c3_r_e_idle", bus.r_e, 0);
        check("c3_round_no_idle", bus.round_no, 0);
        check("c1_pt_held", bus.plaintext, PT1);

        set_key(K2);
        run_block(CT2, 0, '0, pt, lat, pulses, re_n, seq);
        check("c2_pt", pt, PT2);
        check("c2_latency", lat, LAT);

        set_key(K1);
        run_block(CT1, 5, CT2, pt, lat, pulses, re_n, seq);
        check("c4_pt", pt, PT1);
        check("c4_pulses", pulses, 1);

        set_key(K2);
        bus.ciphertext = CT2;
        bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("c5_plaintext", bus.plaintext, 0);
        check("c5_round_no", bus.round_no, 0);
        check("c5_r_e", bus.r_e, 0);
        check("c5_en_o", bus.en_o, 0);
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.en_o) pulses++;
        end
        check("c5_no_done", pulses, 0);
        run_block(CT2, 0, '0, pt, lat, pulses, re_n, seq);
        check("c5_pt_after", pt, PT2);
        check("c5_latency", lat, LAT);

        ct6 = aes_enc(P6);
        run_block(ct6, 0, '0, pt, lat, pulses, re_n, seq);
        check("c6_round_trip", pt, P6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
